// File: rtl/eoc_readout_pkg.sv
// -----------------------------------------------------------------------------
// eoc_readout_pkg
// Shared types and helpers for the end-of-column readout controller.
//   state_t     : readout FSM states
//   hit_word_t  : {addr, ts_le, ts_te} hit word at the default widths
//   bin2gray / gray2bin : width-generic (up to 32 bits) Gray helpers; callers
//                 zero-extend into and truncate out of the 32-bit form.
// Optional build macro used by the controller: GRAY_TS_EN.
// -----------------------------------------------------------------------------
package eoc_readout_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int TS_W_DEF   = 8;

  typedef enum logic [2:0] {
    IDLE,
    FRZ,
    RD,
    REL,
    WAIT_FULL
  } state_t;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [TS_W_DEF-1:0]   ts_le;
    logic [TS_W_DEF-1:0]   ts_te;
  } hit_word_t;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    for (int i = 1; i < 32; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/eoc_hit_fifo.sv
// -----------------------------------------------------------------------------
// eoc_hit_fifo
// First-word fall-through FIFO for hit words. The head entry is presented on
// o_data whenever o_valid is high; o_data reads as zero while empty.
// A push is accepted when not full, or when full together with a pop.
// Ports:
//   CK, RST_B        clock, synchronous active-low reset (discards contents)
//   i_push, i_data   write strobe and word
//   i_pop            consumer pop (ignored while empty)
//   o_data, o_valid  head word, not-empty flag
//   o_full           occupancy == DEPTH
// -----------------------------------------------------------------------------
module eoc_hit_fifo
  import eoc_readout_pkg::*;
#(
  parameter type T     = hit_word_t,
  parameter int  DEPTH = 8
) (
  input  logic CK,
  input  logic RST_B,
  input  logic i_push,
  input  T     i_data,
  input  logic i_pop,
  output T     o_data,
  output logic o_valid,
  output logic o_full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  T                 r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_valid   = (r_count != '0);
  assign o_full    = (r_count == FULL_CNT);
  assign w_do_pop  = i_pop && o_valid;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_data    = o_valid ? r_mem[r_rd_ptr] : '0;

  // Storage is not reset; the count alone decides what is visible.
  always_ff @(posedge CK) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge CK) begin
    if (!RST_B) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/eoc_readout_ctrl.sv
// -----------------------------------------------------------------------------
// eoc_readout_ctrl
// End-of-column readout controller. Broadcasts the column timestamp, freezes
// the pixel chain, drains flagged hits one at a time with READ strobes and
// buffers {addr, ts_le, ts_te} words in a FWFT FIFO for the serializer.
// Ports:
//   CK, RST_B            clock, synchronous active-low reset
//   EN                   gates the start of a new hit sequence only
//   HIT_OR               async OR of chain hit flags (2-FF synchronised)
//   ADDR_OUT_B           inverted pixel address, valid while READ
//   TS_LE_B, TS_TE_B     leading/trailing timestamps, valid while READ
//   READ, FREEZE         chain control strobes
//   TS                   timestamp broadcast
//   DOUT, DOUT_VALID     FIFO head and not-empty
//   DOUT_READY           consumer pop
//   FIFO_FULL, OVF_CNT   full flag, saturating count of back-pressure cycles
// Build macro GRAY_TS_EN: TS is Gray-coded and the captured timestamps are
// Gray-decoded before storage. Without it TS is binary and stored as-is.
// -----------------------------------------------------------------------------
module eoc_readout_ctrl
  import eoc_readout_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int TS_W       = TS_W_DEF,
  parameter int FIFO_DEPTH = 8,
  parameter int READ_CYC   = 2,
  parameter int SETTLE_CYC = 2,
  parameter int TS_DIV     = 4
) (
  input  logic                     CK,
  input  logic                     RST_B,
  input  logic                     EN,
  input  logic                     HIT_OR,
  input  logic [ADDR_W-1:0]        ADDR_OUT_B,
  input  logic [TS_W-1:0]          TS_LE_B,
  input  logic [TS_W-1:0]          TS_TE_B,
  output logic                     READ,
  output logic                     FREEZE,
  output logic [TS_W-1:0]          TS,
  output logic [ADDR_W+2*TS_W-1:0] DOUT,
  output logic                     DOUT_VALID,
  input  logic                     DOUT_READY,
  output logic                     FIFO_FULL,
  output logic [7:0]               OVF_CNT
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [TS_W-1:0]   ts_le;
    logic [TS_W-1:0]   ts_te;
  } word_t;

  localparam int PRE_W   = (TS_DIV > 1) ? $clog2(TS_DIV) : 1;
  localparam int CNT_MAX = (READ_CYC > SETTLE_CYC + 2) ? READ_CYC : SETTLE_CYC + 2;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(READ_CYC - 1);
  // REL lasts SETTLE_CYC plus the two synchroniser cycles so hit_s reflects
  // the chain after the pixel just read has cleared its flag.
  localparam logic [CNT_W-1:0] REL_LAST = CNT_W'(SETTLE_CYC + 1);

  logic [PRE_W-1:0] r_presc;
  logic [TS_W-1:0]  r_ts_bin;
  logic             r_sync1;
  logic             r_sync2;
  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [7:0]       r_ovf;
  logic             w_push;
  logic [TS_W-1:0]  w_cap_le;
  logic [TS_W-1:0]  w_cap_te;
  word_t            w_word;
  word_t            w_head;

  // Free-running timestamp, independent of EN and FSM state.
  always_ff @(posedge CK) begin
    if (!RST_B) begin
      r_presc  <= '0;
      r_ts_bin <= '0;
    end else if (r_presc == PRE_W'(TS_DIV - 1)) begin
      r_presc  <= '0;
      r_ts_bin <= r_ts_bin + 1'b1;
    end else begin
      r_presc  <= r_presc + 1'b1;
    end
  end

`ifdef GRAY_TS_EN
  assign TS       = TS_W'(bin2gray(32'(r_ts_bin)));
  assign w_cap_le = TS_W'(gray2bin(32'(TS_LE_B)));
  assign w_cap_te = TS_W'(gray2bin(32'(TS_TE_B)));
`else
  assign TS       = r_ts_bin;
  assign w_cap_le = TS_LE_B;
  assign w_cap_te = TS_TE_B;
`endif

  always_ff @(posedge CK) begin
    if (!RST_B) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= HIT_OR;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge CK) begin
    if (!RST_B) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = '0;
    w_push       = 1'b0;
    READ         = 1'b0;
    FREEZE       = 1'b0;
    unique case (r_state)
      IDLE: begin
        FREEZE = 1'b1;
        if (EN && r_sync2) w_state_next = FRZ;
      end
      FRZ: begin
        w_state_next = FIFO_FULL ? WAIT_FULL : RD;
      end
      RD: begin
        READ = 1'b1;
        if (r_cnt == RD_LAST) begin
          w_push       = 1'b1;
          w_state_next = REL;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      REL: begin
        if (r_cnt == REL_LAST) begin
          if (!r_sync2)       w_state_next = IDLE;
          else if (FIFO_FULL) w_state_next = WAIT_FULL;
          else                w_state_next = RD;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      WAIT_FULL: begin
        if (!FIFO_FULL) w_state_next = RD;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge CK) begin
    if (!RST_B) begin
      r_ovf <= '0;
    end else if (r_state == WAIT_FULL && r_ovf != 8'hFF) begin
      r_ovf <= r_ovf + 1'b1;
    end
  end
  assign OVF_CNT = r_ovf;

  assign w_word.addr  = ~ADDR_OUT_B;
  assign w_word.ts_le = w_cap_le;
  assign w_word.ts_te = w_cap_te;

  eoc_hit_fifo #(
    .T     (word_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CK      (CK),
    .RST_B   (RST_B),
    .i_push  (w_push),
    .i_data  (w_word),
    .i_pop   (DOUT_READY),
    .o_data  (w_head),
    .o_valid (DOUT_VALID),
    .o_full  (FIFO_FULL)
  );

  assign DOUT = w_head;

endmodule

// File: tb/tb_eoc_readout_ctrl.sv
`timescale 1ns/1ps
// Bench for eoc_readout_ctrl: a pixel-chain model (priority = lowest address,
// joins the chain only while FREEZE=1) plus a word scoreboard and TS model.
module tb_eoc_readout_ctrl;

  localparam int ADDR_W     = 8;
  localparam int TS_W       = 8;
  localparam int FIFO_DEPTH = 8;
  localparam int READ_CYC   = 2;
  localparam int SETTLE_CYC = 2;
  localparam int TS_DIV     = 4;
  localparam int HIT_GAP    = READ_CYC + SETTLE_CYC + 2;

  logic        CK = 1'b0;
  logic        RST_B = 1'b0;
  logic        EN = 1'b1;
  logic        HIT_OR = 1'b0;
  logic [7:0]  ADDR_OUT_B = 8'hFF;
  logic [7:0]  TS_LE_B = 8'h00;
  logic [7:0]  TS_TE_B = 8'h00;
  logic        READ;
  logic        FREEZE;
  logic [7:0]  TS;
  logic [23:0] DOUT;
  logic        DOUT_VALID;
  logic        DOUT_READY = 1'b0;
  logic        FIFO_FULL;
  logic [7:0]  OVF_CNT;

  always #5 CK = ~CK;

  eoc_readout_ctrl #(
    .ADDR_W(ADDR_W), .TS_W(TS_W), .FIFO_DEPTH(FIFO_DEPTH),
    .READ_CYC(READ_CYC), .SETTLE_CYC(SETTLE_CYC), .TS_DIV(TS_DIV)
  ) dut (
    .CK(CK), .RST_B(RST_B), .EN(EN), .HIT_OR(HIT_OR),
    .ADDR_OUT_B(ADDR_OUT_B), .TS_LE_B(TS_LE_B), .TS_TE_B(TS_TE_B),
    .READ(READ), .FREEZE(FREEZE), .TS(TS), .DOUT(DOUT),
    .DOUT_VALID(DOUT_VALID), .DOUT_READY(DOUT_READY),
    .FIFO_FULL(FIFO_FULL), .OVF_CNT(OVF_CNT)
  );

  typedef struct {
    logic [7:0] addr;   // true address; the pixel drives its inverse
    logic [7:0] le_b;   // bus values as driven by the pixel
    logic [7:0] te_b;
  } pix_t;

  typedef struct {
    logic [7:0]  addr_b;
    logic [7:0]  le_b;
    logic [7:0]  te_b;
    logic [23:0] exp;
  } vec_t;

  pix_t        chain[$];
  pix_t        pending[$];
  logic [23:0] sb[$];
  int          pop_log[$];
  int          rise_q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc_no = 0;
  int          ts_n = 0;
  int          read_len = 0;
  int          reads_done = 0;
  logic        prev_read = 1'b0;
  logic        rdy = 1'b0;
  logic        rand_rdy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc_no);
    end
  endtask

  function automatic logic [7:0] ts_enc(input logic [7:0] b);
`ifdef GRAY_TS_EN
    return b ^ (b >> 1);
`else
    return b;
`endif
  endfunction

  function automatic logic [7:0] ts_dec(input logic [7:0] g);
`ifdef GRAY_TS_EN
    logic [7:0] b;
    b[7] = g[7];
    for (int i = 6; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
`else
    return g;
`endif
  endfunction

  function automatic bit addr_busy(input logic [7:0] a);
    foreach (chain[i])   if (chain[i].addr == a)   return 1'b1;
    foreach (pending[i]) if (pending[i].addr == a) return 1'b1;
    return 1'b0;
  endfunction

  task automatic add_hit(input logic [7:0] a, input logic [7:0] le, input logic [7:0] te);
    pix_t p;
    p.addr = a; p.le_b = le; p.te_b = te;
    pending.push_back(p);
  endtask

  task automatic join_chain();
    pix_t t;
    while (pending.size() > 0) begin
      chain.push_back(pending.pop_front());
      for (int i = chain.size() - 1; i > 0; i--) begin
        if (chain[i-1].addr > chain[i].addr) begin
          t = chain[i]; chain[i] = chain[i-1]; chain[i-1] = t;
        end
      end
    end
  endtask

  // One clock: sample at the falling edge, update models, drive inputs.
  task automatic cyc();
    logic rst_at_edge;
    @(posedge CK);
    rst_at_edge = RST_B;
    @(negedge CK);
    cyc_no++;
    if (rst_at_edge) ts_n++;
    else begin
      ts_n = 0;
      sb.delete();
    end
    check("ts", 32'(TS), 32'(ts_enc(8'((ts_n / TS_DIV) % 256))));
    if (READ && !prev_read) rise_q.push_back(cyc_no);
    if (READ) read_len++;
    else if (prev_read) begin
      if (rst_at_edge) begin
        check("read_len", 32'(read_len), 32'(READ_CYC));
        if (chain.size() > 0) begin
          sb.push_back({chain[0].addr, ts_dec(chain[0].le_b), ts_dec(chain[0].te_b)});
          void'(chain.pop_front());
        end
        reads_done++;
      end
      read_len = 0;
    end
    prev_read = READ;
    check("valid", 32'(DOUT_VALID), 32'(sb.size() != 0));
    check("full", 32'(FIFO_FULL), 32'(sb.size() == FIFO_DEPTH));
    if (FREEZE) join_chain();
    HIT_OR = (chain.size() != 0);
    if (chain.size() > 0) begin
      ADDR_OUT_B = ~chain[0].addr;
      TS_LE_B    = chain[0].le_b;
      TS_TE_B    = chain[0].te_b;
    end else begin
      ADDR_OUT_B = 8'hFF;
      TS_LE_B    = 8'h00;
      TS_TE_B    = 8'h00;
    end
    DOUT_READY = rand_rdy ? ($urandom_range(0, 1) == 1) : rdy;
    if (DOUT_VALID && DOUT_READY && sb.size() > 0) begin
      check("dout", 32'(DOUT), 32'(sb[0]));
      pop_log.push_back(int'(DOUT[23:16]));
      void'(sb.pop_front());
    end
  endtask

  task automatic wait_read(input logic lvl, input string name);
    int n;
    n = 0;
    while (READ !== lvl && n < 60) begin
      cyc();
      n++;
    end
    if (READ !== lvl) check(name, 32'(READ), 32'(lvl));
  endtask

  initial begin
    vec_t        vt[4];
    logic [23:0] exp_w;
    int          n;
    int          base;
    int          exp_ord[4];
    pix_t        p;

    vt[0] = '{addr_b: 8'hF5, le_b: 8'h12, te_b: 8'h34, exp: 24'h0A1234};
    vt[1] = '{addr_b: 8'h00, le_b: 8'hFF, te_b: 8'h00, exp: 24'hFFFF00};
    vt[2] = '{addr_b: 8'hFF, le_b: 8'h00, te_b: 8'hFF, exp: 24'h0000FF};
    vt[3] = '{addr_b: 8'h5A, le_b: 8'hA5, te_b: 8'h3C, exp: 24'hA5A53C};
    exp_ord = '{3, 7, 9, 1};

    // ---- reset values and timestamp counter ----
    repeat (3) cyc();
    check("rst_read", 32'(READ), 32'd0);
    check("rst_freeze", 32'(FREEZE), 32'd1);
    check("rst_ts", 32'(TS), 32'd0);
    check("rst_valid", 32'(DOUT_VALID), 32'd0);
    check("rst_full", 32'(FIFO_FULL), 32'd0);
    check("rst_ovf", 32'(OVF_CNT), 32'd0);
    check("rst_dout", 32'(DOUT), 32'd0);
    RST_B = 1'b1;
    for (int k = 1; k <= 1024; k++) begin
      cyc();
      if (k == 4)    check("ts_first_step", 32'(TS), 32'(ts_enc(8'h01)));
      if (k == 1023) check("ts_max", 32'(TS), 32'(ts_enc(8'hFF)));
      if (k == 1024) check("ts_wrap", 32'(TS), 32'(ts_enc(8'h00)));
    end
    check("idle_freeze", 32'(FREEZE), 32'd1);
    check("idle_read", 32'(READ), 32'd0);

    // ---- table: single hits, latency, captured word ----
    for (int i = 0; i < 4; i++) begin
      rdy = 1'b0;
      exp_w = vt[i].exp;
`ifdef GRAY_TS_EN
      exp_w = {~vt[i].addr_b, ts_dec(vt[i].le_b), ts_dec(vt[i].te_b)};
`endif
      add_hit(~vt[i].addr_b, vt[i].le_b, vt[i].te_b);
      cyc();
      n = 0;
      do begin
        cyc();
        n++;
      end while (!READ && n < 20);
      check("latency", 32'(n), 32'd4);
      wait_read(1'b0, "read_fall_timeout");
      repeat (HIT_GAP) cyc();
      check("single_dout", 32'(DOUT), 32'(exp_w));
      check("single_valid", 32'(DOUT_VALID), 32'd1);
      check("single_freeze", 32'(FREEZE), 32'd1);
      rdy = 1'b1;
      repeat (2) cyc();
    end

    // ---- three-pixel chain, EN dropped mid-sequence, late hit ----
    rdy = 1'b1;
    pop_log.delete();
    rise_q.delete();
    base = reads_done;
    add_hit(8'd9, 8'h90, 8'h91);
    add_hit(8'd3, 8'h30, 8'h31);
    add_hit(8'd7, 8'h70, 8'h71);
    cyc();
    wait_read(1'b1, "chain_start_timeout");
    EN = 1'b0;
    add_hit(8'd1, 8'h10, 8'h11);
    n = 0;
    while (reads_done < base + 3 && n < 60) begin
      check("chain_freeze_low", 32'(FREEZE), 32'd0);
      cyc();
      n++;
    end
    check("chain_reads", 32'(reads_done - base), 32'd3);
    if (rise_q.size() >= 3) begin
      check("spacing_1", 32'(rise_q[1] - rise_q[0]), 32'(HIT_GAP));
      check("spacing_2", 32'(rise_q[2] - rise_q[1]), 32'(HIT_GAP));
    end else check("chain_rises", 32'(rise_q.size()), 32'd3);
    repeat (HIT_GAP + 6) cyc();
    check("en_gate_reads", 32'(reads_done - base), 32'd3);
    check("en_gate_freeze", 32'(FREEZE), 32'd1);
    EN = 1'b1;
    n = 0;
    while ((reads_done < base + 4 || sb.size() != 0) && n < 60) begin
      cyc();
      n++;
    end
    check("chain_pops", 32'(pop_log.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (pop_log.size() > i) check("chain_order", 32'(pop_log[i]), 32'(exp_ord[i]));

    // ---- FIFO full, WAIT_FULL overflow count, lossless drain ----
    repeat (HIT_GAP) cyc();
    rdy = 1'b0;
    pop_log.delete();
    check("ovf_before", 32'(OVF_CNT), 32'd0);
    for (int a = 20; a < 30; a++) add_hit(8'(a), 8'(a + 1), 8'(a + 2));
    cyc();
    n = 0;
    while (!FIFO_FULL && n < 200) begin
      cyc();
      n++;
    end
    check("full_reached", 32'(FIFO_FULL), 32'd1);
    check("full_words", 32'(sb.size()), 32'(FIFO_DEPTH));
    repeat (20) cyc();
    check("ovf_cnt", 32'(OVF_CNT), 32'(20 - (SETTLE_CYC + 2)));
    check("wait_read_low", 32'(READ), 32'd0);
    check("wait_freeze_low", 32'(FREEZE), 32'd0);
    rdy = 1'b1;
    n = 0;
    while (pop_log.size() < 10 && n < 300) begin
      cyc();
      n++;
    end
    check("drain_count", 32'(pop_log.size()), 32'd10);
    for (int i = 0; i < 10; i++)
      if (pop_log.size() > i) check("drain_order", 32'(pop_log[i]), 32'(20 + i));
    repeat (HIT_GAP) cyc();
    check("after_full_freeze", 32'(FREEZE), 32'd1);

    // ---- reset during the first READ cycle ----
    rdy = 1'b0;
    add_hit(8'd41, 8'h41, 8'h42);
    cyc();
    wait_read(1'b1, "pre_rst_start");
    wait_read(1'b0, "pre_rst_fall");
    repeat (HIT_GAP) cyc();
    check("pre_rst_valid", 32'(DOUT_VALID), 32'd1);
    add_hit(8'd42, 8'h43, 8'h44);
    cyc();
    wait_read(1'b1, "rst_rd_start");
    RST_B = 1'b0;
    cyc();
    check("rst_rd_read", 32'(READ), 32'd0);
    check("rst_rd_valid", 32'(DOUT_VALID), 32'd0);
    check("rst_rd_freeze", 32'(FREEZE), 32'd1);
    check("rst_rd_ovf", 32'(OVF_CNT), 32'd0);
    chain.delete();
    pending.delete();
    repeat (2) cyc();
    RST_B = 1'b1;
    repeat (4) cyc();

`ifdef GRAY_TS_EN
    // ---- Gray decode of a captured timestamp ----
    add_hit(8'd5, 8'h1E, 8'h00);
    cyc();
    wait_read(1'b1, "gray_start");
    wait_read(1'b0, "gray_fall");
    cyc();
    check("gray_le", 32'(DOUT[15:8]), 32'h14);
    rdy = 1'b1;
    repeat (HIT_GAP) cyc();
`endif

    // ---- randomized traffic against the models ----
    rand_rdy = 1'b1;
    for (int k = 0; k < 1500; k++) begin
      if (k % 50 == 0) EN = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) begin
        p.addr = 8'($urandom_range(0, 255));
        p.le_b = 8'($urandom_range(0, 255));
        p.te_b = 8'($urandom_range(0, 255));
        if (!addr_busy(p.addr)) add_hit(p.addr, p.le_b, p.te_b);
      end
      cyc();
    end
    rand_rdy = 1'b0;
    rdy = 1'b1;
    EN = 1'b1;
    n = 0;
    while ((chain.size() != 0 || pending.size() != 0 || sb.size() != 0 || !FREEZE) && n < 3000) begin
      cyc();
      n++;
    end
    check("final_chain_empty", 32'(chain.size() + pending.size()), 32'd0);
    check("final_sb_empty", 32'(sb.size()), 32'd0);
    check("final_valid", 32'(DOUT_VALID), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc_no);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/eoc_readout_ctrl.md
Name: eoc_readout_ctrl

Overview:
End-of-column readout controller, directly downstream of the column's chain of digitalFrontEnd pixels. It generates the column timestamp bus (TS), FREEZE and READ. It drains latched hits through the priority chain one at a time and captures address, leading-edge and trailing-edge timestamps. Each hit is packed into a 24-bit word and buffered in a small FIFO for the periphery serializer.

Parameters:
ADDR_W, 8, pixel address width
TS_W, 8, timestamp width
FIFO_DEPTH, 8, hit-word FIFO entries (power of 2, >=2)
READ_CYC, 2, cycles READ is held high per hit (>=1)
SETTLE_CYC, 2, cycles after READ falls before HIT_OR is evaluated (excludes 2-cycle sync; >=1)
TS_DIV, 4, CK cycles per timestamp increment (>=1)

Ports:
CK  in  1  clock
RST_B  in  1  synchronous active-low reset
EN  in  1  readout enable; when 0, no new hit sequence starts
HIT_OR  in  1  HIT_OUT of the last pixel in the chain (async; any flagged hit)
ADDR_OUT_B  in  ADDR_W  inverted pixel address bus, valid while READ high
TS_LE_B  in  TS_W  leading-edge timestamp bus, valid while READ high
TS_TE_B  in  TS_W  trailing-edge timestamp bus, valid while READ high
READ  out  1  read strobe to the pixel chain
FREEZE  out  1  1 = pixels may transfer completed hits into the chain
TS  out  TS_W  timestamp broadcast to pixels
DOUT  out  ADDR_W+2*TS_W  FIFO head {addr, ts_le, ts_te}
DOUT_VALID  out  1  FIFO not empty
DOUT_READY  in  1  consumer pop; pop occurs when VALID & READY
FIFO_FULL  out  1  FIFO occupancy == FIFO_DEPTH
OVF_CNT  out  8  saturating count of cycles spent in WAIT_FULL

Behaviour:
- Reset values (RST_B low at rising CK): READ=0, FREEZE=1, TS=0, DOUT_VALID=0, FIFO_FULL=0, OVF_CNT=0, DOUT=0, state IDLE, sync flops 0. Reset mid-sequence aborts immediately: READ drops, and FIFO contents are discarded.
- TS counter: prescaler counts 0..TS_DIV-1. TS increments by 1 on prescaler wrap, mod 2^TS_W (0xFF→0x00). It runs regardless of EN and state.
- HIT_OR passes through a 2-FF synchronizer to produce hit_s.
- FSM:
  - IDLE: FREEZE=1, READ=0. If EN & hit_s → FRZ.
  - FRZ: FREEZE=0 for 1 cycle (freezes the hit set), then → RD if FIFO not full, else → WAIT_FULL.
  - RD: READ=1 for exactly READ_CYC cycles. On the last cycle, capture addr=~ADDR_OUT_B, ts_le=TS_LE_B, ts_te=TS_TE_B, and push {addr,ts_le,ts_te} into the FIFO. → REL.
  - REL: READ=0, FREEZE=0 for SETTLE_CYC+2 cycles, then: hit_s & FIFO not full → RD; hit_s & FIFO full → WAIT_FULL; !hit_s → IDLE (FREEZE returns to 1 on entry).
  - WAIT_FULL: READ=0, FREEZE=0. OVF_CNT increments per cycle, saturating at 255. Exit to RD when FIFO not full. No data is lost.
- EN deassertion mid-sequence: the current frozen set is drained completely; EN only gates IDLE→FRZ.
- Latency: HIT_OR rise → READ rise = 2 (sync) + 1 (IDLE) + 1 (FRZ) = 4 cycles. Consecutive hits are spaced READ_CYC+SETTLE_CYC+2 cycles apart.
- FIFO: synchronous, first-word fall-through (DOUT valid whenever DOUT_VALID=1).
  - Simultaneous push and pop when full: legal. Occupancy is unchanged.
  - Simultaneous push and pop when empty: the pushed word appears next cycle.
  - Pointers wrap modulo FIFO_DEPTH. Occupancy counter is log2(FIFO_DEPTH)+1 bits.
- DOUT_READY while DOUT_VALID=0 has no effect.

Optional Feature:
GRAY_TS_EN. When defined, TS is driven Gray-coded (bin ^ (bin>>1)), and captured ts_le/ts_te are Gray→binary decoded before the FIFO push. Capture latency is unchanged (decode is combinational in the capture cycle). When undefined, TS is plain binary and the buses are stored as-is.

Decomposition:
- Package eoc_readout_pkg holds:
  - state enum (IDLE, FRZ, RD, REL, WAIT_FULL);
  - hit_word_t struct {addr, ts_le, ts_te};
  - gray2bin/bin2gray functions;
  - default width constants.
- Sub-module: eoc_hit_fifo (parameterised FWFT FIFO of hit_word_t).

Test Plan:
- Reset with TS_DIV=4: after RST_B release, TS=0x00, advancing to 0x01 after 4 CKs; after 1024 CKs it wraps 0xFF→0x00. FREEZE=1, READ=0.
- Single hit: HIT_OR high, pixel model drives ADDR_OUT_B=0xF5, TS_LE_B=0x12, TS_TE_B=0x34 → READ rises 4 cycles later and stays high 2 cycles. DOUT={0x0A,0x12,0x34} with DOUT_VALID=1; FSM returns to IDLE and FREEZE returns to 1.
- Three-pixel chain with addresses 3, 7, 9 → three words in priority order 3, 7, 9. READ pulses are spaced 6 cycles apart. FREEZE stays 0 throughout, and a new hit arriving mid-sequence is read only after FREEZE returns to 1.
- FIFO full: DOUT_READY=0, 10 pending hits, FIFO_DEPTH=8 → 8 words stored, FIFO_FULL=1, state WAIT_FULL, OVF_CNT counting. Raising DOUT_READY drains all 10 words in order with no loss.
- Reset mid-RD: RST_B low during the first READ cycle → READ=0 next edge, DOUT_VALID=0, FREEZE=1.
- With GRAY_TS_EN: TS sequence 0,1,3,2,6…; pixel returns Gray 0x1E → stored ts_le = 0x14.
